// File: rtl/sprite_line_renderer.sv
// Fetches one 32-pixel sprite row per accepted entry and writes its opaque pixels into the line buffer.
// Latency: 1 + (READ_LATENCY+1) + 32 clocks per sprite; writes trail each DRAW cycle by one clock.
// Backpressure: sprite_ready is high only in ACCEPT. Optional overlap priority/flag via SPRITE_COLLISION_EN.
module sprite_line_renderer #(
    parameter int READ_LATENCY = 1,
    parameter int SCREEN_W     = 320,
    parameter int X_W          = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             line_start,
    input  logic             sprite_valid,
    output logic             sprite_ready,
    input  logic [X_W-1:0]   sprite_x,
    input  logic [11:0]      sprite_line_addr,
    input  logic             sprite_hflip,
    input  logic             sprite_last,
    output logic [11:0]      read_addr,
    input  logic [255:0]     read_data,
    output logic             lb_we,
    output logic [X_W-1:0]   lb_addr,
    output logic [7:0]       lb_data,
    output logic             busy,
    output logic             done,
    output logic             collision
);

    typedef enum logic [2:0] {IDLE, ACCEPT, FETCH, DRAW, DONE} state_t;

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

    state_t         state;
    logic [X_W-1:0] x_r;
    logic           hflip_r;
    logic           last_r;
    logic [2:0]     lat_cnt;
    logic [4:0]     k;
    logic [255:0]   row;

    logic [4:0]     src;
    logic [7:0]     pix_base;
    logic [7:0]     pix;
    logic [X_W:0]   tgt;
    logic           wr_cand;
    logic           wr_en;

    assign sprite_ready = (state == ACCEPT);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    // Target is one bit wider than X so sprites near the right edge clip instead of wrapping.
    always_comb begin
        src      = hflip_r ? (5'd31 - k) : k;
        pix_base = {src, 3'b000};
        pix      = row[pix_base +: 8];
        tgt      = {1'b0, x_r} + {{(X_W-4){1'b0}}, k};
        wr_cand  = (state == DRAW) && (pix != 8'd0) && (tgt < (X_W+1)'(SCREEN_W));
    end

`ifdef SPRITE_COLLISION_EN
    localparam int BW = $clog2(SCREEN_W);

    logic [SCREEN_W-1:0] occ;
    logic                coll_r;
    logic                hit;

    assign hit       = wr_cand && occ[tgt[BW-1:0]];
    assign wr_en     = wr_cand && !hit;
    assign collision = coll_r;

    // First writer of a pixel owns it for the rest of the scanline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ    <= '0;
            coll_r <= 1'b0;
        end else if (state == IDLE && line_start) begin
            occ    <= '0;
            coll_r <= 1'b0;
        end else if (wr_cand) begin
            if (hit) begin
                coll_r <= 1'b1;
            end else begin
                occ[tgt[BW-1:0]] <= 1'b1;
            end
        end
    end
`else
    assign wr_en     = wr_cand;
    assign collision = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            read_addr <= '0;
            x_r       <= '0;
            hflip_r   <= 1'b0;
            last_r    <= 1'b0;
            lat_cnt   <= '0;
            k         <= '0;
            row       <= '0;
            lb_we     <= 1'b0;
            lb_addr   <= '0;
            lb_data   <= '0;
        end else begin
            lb_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_start) state <= ACCEPT;
                end
                ACCEPT: begin
                    if (sprite_valid) begin
                        read_addr <= sprite_line_addr;
                        x_r       <= sprite_x;
                        hflip_r   <= sprite_hflip;
                        last_r    <= sprite_last;
                        lat_cnt   <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_cnt == LAT_LAST) begin
                        row   <= read_data;
                        k     <= '0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    lb_we   <= wr_en;
                    lb_addr <= tgt[X_W-1:0];
                    lb_data <= pix;
                    k       <= k + 5'd1;
                    if (k == 5'd31) state <= last_r ? DONE : ACCEPT;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Scoreboard bench for sprite_line_renderer: expected line-buffer writes are queued at each handshake.
module tb_sprite_line_renderer;

    localparam int RL  = 1;
    localparam int SW  = 320;
    localparam int XW  = 10;
    localparam int SPRITE_CYC = 1 + (RL + 1) + 32;
`ifdef SPRITE_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           line_start = 1'b0;
    logic           sprite_valid = 1'b0;
    logic           sprite_ready;
    logic [XW-1:0]  sprite_x = '0;
    logic [11:0]    sprite_line_addr = '0;
    logic           sprite_hflip = 1'b0;
    logic           sprite_last = 1'b0;
    logic [11:0]    read_addr;
    logic [255:0]   read_data;
    logic           lb_we;
    logic [XW-1:0]  lb_addr;
    logic [7:0]     lb_data;
    logic           busy;
    logic           done;
    logic           collision;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;
    bit          occ[SW];
    bit          exp_coll = 1'b0;
    logic [255:0] rd_pipe[RL];

    sprite_line_renderer #(.READ_LATENCY(RL), .SCREEN_W(SW), .X_W(XW)) dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start),
        .sprite_valid(sprite_valid), .sprite_ready(sprite_ready),
        .sprite_x(sprite_x), .sprite_line_addr(sprite_line_addr),
        .sprite_hflip(sprite_hflip), .sprite_last(sprite_last),
        .read_addr(read_addr), .read_data(read_data),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .busy(busy), .done(done), .collision(collision)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] vram_row(input logic [11:0] a);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] p;
            if (a == 12'h005)      p = 8'(i + 1);
            else if (a == 12'h006) p = (i % 2 == 1) ? 8'(i + 1) : 8'h00;
            else                   p = 8'h80 | {1'b0, a[1:0], 5'(i)};
            r = r | (256'(p) << (8 * i));
        end
        return r;
    endfunction

    // VRAM: address sampled at each edge, data appears RL edges later.
    always @(posedge clk) begin
        rd_pipe[0] <= vram_row(read_addr);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign read_data = rd_pipe[RL-1];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (lb_we) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL lb_write unexpected: got addr=%0d data=%0d, required no write", lb_addr, lb_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({lb_addr, lb_data} !== mon_e) begin
                    failures++;
                    $display("FAIL lb_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             lb_addr, lb_data, mon_e[17:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic push_sprite(input int x, input logic [11:0] a, input bit hf);
        logic [255:0] r;
        logic [7:0]   p;
        int s, t;
        r = vram_row(a);
        for (int k = 0; k < 32; k++) begin
            s = hf ? 31 - k : k;
            p = 8'(r >> (8 * s));
            t = x + k;
            if (p != 8'd0 && t < SW) begin
                if (COLL && occ[t]) begin
                    exp_coll = 1'b1;
                end else begin
                    occ[t] = 1'b1;
                    exp_q.push_back({10'(t), p});
                end
            end
        end
    endtask

    task automatic start_line();
        @(negedge clk); line_start = 1'b1;
        @(negedge clk); line_start = 1'b0;
        exp_coll = 1'b0;
        for (int i = 0; i < SW; i++) occ[i] = 1'b0;
        checks++;
        if (busy !== 1'b1 || collision !== 1'b0 || sprite_ready !== 1'b1) begin
            failures++;
            $display("FAIL line_start: got busy=%b ready=%b collision=%b, required 1 1 0", busy, sprite_ready, collision);
        end
    endtask

    task automatic send_entry(input int x, input logic [11:0] a, input bit hf, input bit last, input int gap);
        int n = 0;
        while (sprite_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (sprite_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout: got sprite_ready=%b, required 1", sprite_ready);
            return;
        end
        if (gap > 0) begin
            repeat (gap) @(negedge clk);
            checks++;
            if (sprite_ready !== 1'b1) begin
                failures++;
                $display("FAIL ready_hold: got sprite_ready=%b after idle gap, required 1", sprite_ready);
            end
        end
        sprite_x = XW'(x); sprite_line_addr = a; sprite_hflip = hf; sprite_last = last;
        sprite_valid = 1'b1;
        @(posedge clk);
        push_sprite(x, a, hf);
        @(negedge clk);
        sprite_valid = 1'b0;
        hs_cyc = cyc;
        checks++;
        if (read_addr !== a || sprite_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL handshake: got read_addr=%h ready=%b busy=%b, required read_addr=%h ready=0 busy=1",
                     read_addr, sprite_ready, busy, a);
        end
    endtask

    // Follows one sprite through FETCH/DRAW; optionally pulses line_start or asserts reset at a cycle.
    task automatic watch_sprite(input int ls_at, input int rst_at);
        bit bad = 1'b0;
        for (int i = 2; i <= SPRITE_CYC - 1; i++) begin
            @(negedge clk);
            line_start = (i == ls_at);
            if (i == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                checks++;
                if (lb_we !== 1'b0 || busy !== 1'b0 || sprite_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL async_reset: got lb_we=%b busy=%b ready=%b, required 0 0 0", lb_we, busy, sprite_ready);
                end
                return;
            end
            if (sprite_ready !== 1'b0) bad = 1'b1;
        end
        line_start = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL ready_in_fetch_draw: got sprite_ready=1 outside ACCEPT, required 0");
        end
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: got done=%b, required 1", done);
        end else if (cyc - hs_cyc + 1 != SPRITE_CYC) begin
            failures++;
            $display("FAIL done_latency: got %0d cycles, required %0d", cyc - hs_cyc + 1, SPRITE_CYC);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL line_end: got done=%b busy=%b pending=%0d done_pulses=%0d, required 0 0 0 %0d",
                     done, busy, exp_q.size(), done_cnt - d0, 1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sprite_ready !== 1'b0 || read_addr !== 12'h000 || lb_we !== 1'b0 || lb_addr !== '0 ||
            lb_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || collision !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b read_addr=%h lb_we=%b lb_addr=%0d lb_data=%0d busy=%b done=%b coll=%b, required all 0",
                     sprite_ready, read_addr, lb_we, lb_addr, lb_data, busy, done, collision);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input bit hf);
        int d0 = done_cnt;
        int w0 = wr_cnt;
        start_line();
        send_entry(10, 12'h005, hf, 1'b1, 0);
        watch_sprite(0, 0);
        wait_done(d0);
        checks++;
        if (wr_cnt - w0 != 32) begin
            failures++;
            $display("FAIL basic_count hflip=%0d: got %0d writes, required 32", hf, wr_cnt - w0);
        end
    endtask

    task automatic test_clip();
        int d0 = done_cnt;
        int w0 = wr_cnt;
        start_line();
        send_entry(300, 12'h006, 1'b0, 1'b1, 0);
        watch_sprite(0, 0);
        wait_done(d0);
        checks++;
        if (wr_cnt - w0 != 10) begin
            failures++;
            $display("FAIL clip_partial: got %0d writes, required 10", wr_cnt - w0);
        end
        d0 = done_cnt;
        w0 = wr_cnt;
        start_line();
        send_entry(400, 12'h005, 1'b0, 1'b1, 0);
        watch_sprite(0, 0);
        wait_done(d0);
        checks++;
        if (wr_cnt - w0 != 0) begin
            failures++;
            $display("FAIL clip_offscreen: got %0d writes, required 0", wr_cnt - w0);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        start_line();
        send_entry(20, 12'h020, 1'b0, 1'b0, 5);
        watch_sprite(0, 0);
        send_entry(60, 12'h021, 1'b1, 1'b0, 5);
        watch_sprite(20, 0);
        send_entry(100, 12'h022, 1'b0, 1'b1, 5);
        watch_sprite(0, 0);
        wait_done(d0);
    endtask

    task automatic test_collision();
        int d0 = done_cnt;
        int w0 = wr_cnt;
        start_line();
        send_entry(50, 12'h010, 1'b0, 1'b0, 0);
        watch_sprite(0, 0);
        send_entry(60, 12'h011, 1'b0, 1'b1, 0);
        watch_sprite(0, 0);
        wait_done(d0);
        checks++;
        if (collision !== exp_coll || wr_cnt - w0 != (COLL ? 42 : 64)) begin
            failures++;
            $display("FAIL collision: got flag=%b writes=%0d, required flag=%b writes=%0d",
                     collision, wr_cnt - w0, exp_coll, COLL ? 42 : 64);
        end
        d0 = done_cnt;
        start_line();
        send_entry(400, 12'h005, 1'b0, 1'b1, 0);
        watch_sprite(0, 0);
        wait_done(d0);
    endtask

    task automatic test_reset_mid_draw();
        int w0, d0;
        start_line();
        send_entry(10, 12'h005, 1'b0, 1'b1, 0);
        watch_sprite(0, 15);
        checks++;
        if (exp_q.size() != 20) begin
            failures++;
            $display("FAIL pre_reset_writes: got %0d pending, required 20", exp_q.size());
        end
        exp_q.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (45) @(negedge clk);
        checks++;
        if (wr_cnt != w0 || busy !== 1'b0 || sprite_ready !== 1'b0 || done_cnt != d0) begin
            failures++;
            $display("FAIL post_reset: got writes=%0d busy=%b ready=%b done_pulses=%0d, required 0 0 0 0",
                     wr_cnt - w0, busy, sprite_ready, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_clip();
        test_back_to_back();
        test_collision();
        test_reset_mid_draw();
        test_basic(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
- Downstream consumer of the sprite VRAM read port, 12-bit line address in and 256-bit row out.
- Per scanline, accepts a stream of sprite entries. Each entry gives a screen X and a VRAM sprite-line address.
- For each entry: fetch the 32-pixel row (8 bits per pixel), then serialise the non-transparent pixels into the scanline buffer write port, one pixel per clock.
- Sits between the sprite evaluation stage (upstream, valid/ready) and the line buffer feeding video output.

Parameters:
- READ_LATENCY, 1, VRAM read latency in clocks, from read_addr sampled to read_data valid (1..4).
- SCREEN_W, 320, visible pixels per scanline; writes at or beyond this are dropped.
- X_W, 10, width of sprite_x and lb_addr.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse: begin a new scanline.
- sprite_valid  in  1  upstream entry valid.
- sprite_ready  out  1  block can accept an entry.
- sprite_x  in  X_W  screen X of sprite pixel 0.
- sprite_line_addr  in  12  VRAM sprite-line address.
- sprite_hflip  in  1  horizontal mirror.
- sprite_last  in  1  entry is the final one for this scanline.
- read_addr  out  12  to VRAM read port.
- read_data  in  256  from VRAM; pixel i = read_data[8*i +: 8].
- lb_we  out  1  line buffer write enable.
- lb_addr  out  X_W  line buffer pixel address.
- lb_data  out  8  pixel value.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the scanline is finished.
- collision  out  1  sticky sprite-overlap flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. sprite_ready, read_addr, lb_we, lb_addr, lb_data, busy, done and collision are all 0. Reset mid-operation abandons the current sprite immediately; no further lb_we.
- FSM states: IDLE, ACCEPT, FETCH, DRAW, DONE.
- IDLE:
  - line_start -> ACCEPT.
  - collision clears on line_start.
  - line_start in any other state is ignored.
- ACCEPT:
  - sprite_ready = 1 only in this state, combinational from state.
  - Handshake on sprite_valid & sprite_ready at a rising edge. That edge registers read_addr <= sprite_line_addr and latches x, hflip and last. Then -> FETCH, latency counter = 0.
  - With no valid, wait indefinitely.
- FETCH:
  - Counter increments each clock.
  - At the (READ_LATENCY+1)-th edge after the handshake, latch read_data into a 256-bit row register -> DRAW, pixel counter k = 0.
  - read_addr holds its value until the next handshake.
- DRAW: 32 cycles, k = 0..31. Each cycle:
  - Source index s = hflip ? 31-k : k.
  - Pixel p = row[8*s +: 8].
  - Target t = x + k, computed X_W+1 bits wide (no wrap).
  - Registered outputs next edge: lb_we = (p != 0) && (t < SCREEN_W); lb_addr = t[X_W-1:0]; lb_data = p.
  - Value 0 is transparent and never written.
  - After k = 31: if last -> DONE, else -> ACCEPT.
- DONE: done = 1 for exactly one cycle -> IDLE.
- lb_we is 0 in every state except the cycle following each DRAW cycle.
- Per-sprite cost: 1 + (READ_LATENCY+1) + 32 clocks. Entries are processed strictly in acceptance order.
- x ≥ SCREEN_W: all 32 pixels dropped, timing unchanged.
- x + 31 straddling SCREEN_W: partial write.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined:
  - SCREEN_W-bit occupancy bitmap, cleared on line_start and reset.
  - A pixel write sets its bit.
  - If the bit is already set, lb_we is suppressed for that pixel, so the earlier-accepted sprite has priority, and collision is set (sticky until the next line_start).
- Undefined:
  - No bitmap; later sprites overwrite earlier ones.
  - collision is tied 0.

Test Plan:
- Reset then line_start, one entry: x=10, addr=0x005, last=1, row pixel i = i+1 -> 32 writes at lb_addr 10..41 with data 1..32. read_addr=0x005. done pulses once, 35 cycles after the handshake (READ_LATENCY=1).
- Same entry with hflip=1 -> lb_addr 10..41 receive data 32..1.
- Row with even pixels = 0, x=300 -> writes only odd k with t<320: addresses 301,303,...,319. No write at ≥320. Entry x=400 -> zero writes, done still pulses.
- Three entries with sprite_valid gapped 5 idle cycles between them -> sprite_ready high only in ACCEPT; handshakes in order; lb write streams non-overlapping in time; done after the third only. A line_start mid-DRAW is ignored.
- Assert reset_n=0 at DRAW k=12 -> lb_we, busy, sprite_ready drop to 0 asynchronously. After release, state is IDLE and no stray writes occur.
- SPRITE_COLLISION_EN: sprites A x=50 then B x=60, both fully opaque -> addresses 60..81 written only by A; collision=1; collision clears on the next line_start. With the macro undefined -> B overwrites 60..81 and collision stays 0.
